// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the byte requesters, the arbiter and the uart_top transmit path.
// The slave side is the arbiter. The master side is the requesters plus uart_top (or a bench).
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   done;
    logic [7:0]           uart_data;
    logic                 uart_send;
    logic                 uart_busy;
    logic                 active;
    logic [IDW-1:0]       active_id;
    logic                 err_timeout;

    modport master (
        output req, req_data, uart_busy,
        input  ack, done, uart_data, uart_send, active, active_id, err_timeout
    );

    modport slave (
        input  req, req_data, uart_busy,
        output ack, done, uart_data, uart_send, active, active_id, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_top transmit path among NUM_REQ byte requesters.
// It grants, latches and sends one byte, then tracks busy to report completion or a start timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16,
    parameter int IDW          = 2
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);
    localparam int CW = $clog2(BUSY_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_START = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [IDW-1:0]     r_last_grant;
    logic [IDW-1:0]     r_active_id;
    logic [CW-1:0]      r_cnt;
    logic [7:0]         r_data;
    logic               r_send;
    logic               r_err;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] r_done;

    logic [7:0]         w_bytes [NUM_REQ];
    logic               w_grant_ok;
    logic [IDW-1:0]     w_winner;
    logic [IDW:0]       w_pos;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
            assign w_bytes[gi] = bus.req_data[8*gi +: 8];
        end
    endgenerate

    // Scan from the farthest slot to the nearest one after last_grant, so the nearest set request wins.
    always_comb begin
        w_grant_ok = 1'b0;
        w_winner   = '0;
        w_pos      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_pos = {1'b0, r_last_grant} + (IDW+1)'(k);
            if (w_pos >= (IDW+1)'(NUM_REQ)) begin
                w_pos = w_pos - (IDW+1)'(NUM_REQ);
            end
            if (bus.req[w_pos[IDW-1:0]]) begin
                w_grant_ok = 1'b1;
                w_winner   = w_pos[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= IDW'(NUM_REQ - 1);
            r_active_id  <= '0;
            r_cnt        <= '0;
            r_data       <= 8'h00;
            r_send       <= 1'b0;
            r_err        <= 1'b0;
            r_ack        <= '0;
            r_done       <= '0;
        end else begin
            r_send <= 1'b0;
            r_err  <= 1'b0;
            r_ack  <= '0;
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    // Busy gate also protects against a frame left running by a reset.
                    if (w_grant_ok && !bus.uart_busy) begin
                        r_data          <= w_bytes[w_winner];
                        r_send          <= 1'b1;
                        r_ack[w_winner] <= 1'b1;
                        r_active_id     <= w_winner;
                        r_last_grant    <= w_winner;
                        r_cnt           <= '0;
                        r_state         <= ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    if (bus.uart_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!bus.uart_busy) begin
                        r_done[r_active_id] <= 1'b1;
                        r_state             <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ack         = r_ack;
    assign bus.done        = r_done;
    assign bus.uart_data   = r_data;
    assign bus.uart_send   = r_send;
    assign bus.active      = (r_state != ST_IDLE);
    assign bus.active_id   = r_active_id;
    assign bus.err_timeout = r_err;
endmodule
